// File: rtl/wifi_frame_buffer_if.sv
// Groups the control, AHB, stream and status signals of wifi_frame_buffer.
// The slave side is the buffer; the master side is whoever drives it.
interface wifi_frame_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_FIFO  = 8
);
  logic                  mode;
  logic                  start;
  logic                  flush;
  logic [ADDR_FIFO:0]    data_size;
  logic [ADDR_FIFO-1:0]  base_addr;
  logic                  ahb_we;
  logic                  ahb_re;
  logic [ADDR_FIFO-1:0]  ahb_addr;
  logic [DATA_WIDTH-1:0] ahb_wdata;
  logic [DATA_WIDTH-1:0] ahb_rdata;
  logic                  s_wr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_rd;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_rvalid;
  logic [ADDR_FIFO:0]    level;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  frame_done;
  logic                  busy;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  mode, start, flush, data_size, base_addr,
    input  ahb_we, ahb_re, ahb_addr, ahb_wdata,
    input  s_wr, s_wdata, s_rd,
    output ahb_rdata, s_rdata, s_rvalid, level,
    output full, empty, almost_full, almost_empty,
    output frame_done, busy, overflow, underflow
  );

  modport master (
    output mode, start, flush, data_size, base_addr,
    output ahb_we, ahb_re, ahb_addr, ahb_wdata,
    output s_wr, s_wdata, s_rd,
    input  ahb_rdata, s_rdata, s_rvalid, level,
    input  full, empty, almost_full, almost_empty,
    input  frame_done, busy, overflow, underflow
  );
endinterface

// File: rtl/wifi_frame_buffer.sv
// Single-clock WiFi PHY frame buffer: AHB fills/drains frames by address while
// the PHY streams them out (TX) or in (RX) from a programmable wrapping base.
module wifi_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_FIFO  = 8,
  parameter int DEPTH_FIFO = 200,
  parameter int AF_LEVEL   = 192,
  parameter int AE_LEVEL   = 8
) (
  input  logic               CLK,
  input  logic               rst_n,
  wifi_frame_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ADDR_FIFO:0]   DEPTH_W   = (ADDR_FIFO+1)'(DEPTH_FIFO);
  localparam logic [ADDR_FIFO:0]   AF_W      = (ADDR_FIFO+1)'(AF_LEVEL);
  localparam logic [ADDR_FIFO:0]   AE_W      = (ADDR_FIFO+1)'(AE_LEVEL);
  localparam logic [ADDR_FIFO:0]   CNT_ONE   = (ADDR_FIFO+1)'(1);
  localparam logic [ADDR_FIFO-1:0] ADDR_ONE  = ADDR_FIFO'(1);
  localparam logic [ADDR_FIFO-1:0] LAST_ADDR = ADDR_FIFO'(DEPTH_FIFO - 1);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_FIFO:0]    size_q, size_d;
  logic [ADDR_FIFO:0]    count_q, count_d;
  logic [ADDR_FIFO-1:0]  addr_q, addr_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] s_rdata_q;
  logic [DATA_WIDTH-1:0] ahb_rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_FIFO];

  logic                  start_ok;
  logic                  ahb_in_range;
  logic                  stream_wr;
  logic                  stream_rd;
  logic                  mem_we;
  logic [ADDR_FIFO-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_FIFO:0]    level;
  logic [ADDR_FIFO:0]    count_inc;
  logic [ADDR_FIFO-1:0]  addr_next;

  assign start_ok     = bus.start && (bus.data_size != '0) && (bus.data_size <= DEPTH_W);
  assign ahb_in_range = ({1'b0, bus.ahb_addr} < DEPTH_W);
  assign count_inc    = count_q + CNT_ONE;
  // addr_q walks base_q + count incrementally, so the wrap is a compare-and-reset
  // rather than a modulo on a non-power-of-two depth.
  assign addr_next    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;

  always_comb begin
    level = '0;
    if (state_q != IDLE) level = mode_q ? (size_q - count_q) : count_q;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the if/case tree can leave a latch behind.
    state_d   = state_q;
    mode_d    = mode_q;
    size_d    = size_q;
    count_d   = count_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    done_d    = 1'b0;
    stream_wr = 1'b0;
    stream_rd = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          stream_wr = !mode_q && bus.s_wr;
          stream_rd = mode_q && bus.s_rd;
          if (stream_wr || stream_rd) begin
            count_d = count_inc;
            addr_d  = addr_next;
            if (count_inc == size_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          if (start_ok) begin
            state_d = RUN;
            mode_d  = bus.mode;
            size_d  = bus.data_size;
            addr_d  = bus.base_addr;
            count_d = '0;
          end
        end
      endcase
      // Strobes outside a live frame: RX writes overflow, TX reads underflow.
      if (bus.s_wr && (state_q == IDLE || (state_q == DONE && !mode_q))) ovf_d = 1'b1;
      if (bus.s_rd && (level == '0) && (state_q == IDLE || mode_q)) unf_d = 1'b1;
    end
    rvalid_d = stream_rd;
  end

  // AHB owns the write port outside RUN; the stream owns it during an RX frame.
  assign mem_we    = stream_wr || (bus.ahb_we && (state_q != RUN) && ahb_in_range);
  assign mem_waddr = stream_wr ? addr_q : bus.ahb_addr;
  assign mem_wdata = stream_wr ? bus.s_wdata : bus.ahb_wdata;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      size_q      <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      done_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      s_rdata_q   <= '0;
      ahb_rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      mode_q   <= mode_d;
      size_q   <= size_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      if (stream_rd) s_rdata_q <= mem[addr_q];
      if (bus.ahb_re) ahb_rdata_q <= ahb_in_range ? mem[bus.ahb_addr] : '0;
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and flush,
  // which keeps it mappable onto a plain RAM macro.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.ahb_rdata    = ahb_rdata_q;
  assign bus.s_rdata      = s_rdata_q;
  assign bus.s_rvalid     = rvalid_q;
  assign bus.level        = level;
  assign bus.empty        = (level == '0);
  assign bus.full         = (state_q != IDLE) && (mode_q ? (count_q == '0) : (count_q == size_q));
  assign bus.almost_full  = (level >= AF_W);
  assign bus.almost_empty = (level <= AE_W);
  assign bus.frame_done   = done_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: doc/wifi_frame_buffer.md
# wifi_frame_buffer

Single-clock, parametrised frame buffer for the WiFi PHY, successor to the dual-clock WiFi FIFO. It sits between the AHB slave interface and the PHY datapath. TX mode: AHB fills a frame by address and the PHY streams it out. RX mode: the PHY streams a frame in and AHB reads it by address. Over the previous block it adds a frame-length FSM, a programmable base with non-power-of-two wrap, level/threshold flags, sticky overflow/underflow, and flush.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_FIFO, 8, address width; DEPTH_FIFO ≤ 2^ADDR_FIFO required
- DEPTH_FIFO, 200, memory depth in words (need not be a power of two)
- AF_LEVEL, 192, almost_full threshold (level ≥ AF_LEVEL)
- AE_LEVEL, 8, almost_empty threshold (level ≤ AE_LEVEL)

Ports:
- CLK  in  1  single clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- mode  in  1  1 = TX (AHB write / stream read), 0 = RX (stream write / AHB read); sampled at start
- start  in  1  one-cycle frame start
- flush  in  1  abort to IDLE
- data_size  in  ADDR_FIFO+1  frame length in words, valid 1..DEPTH_FIFO
- base_addr  in  ADDR_FIFO  first stream address, < DEPTH_FIFO; sampled at start
- ahb_we / ahb_re  in  1  AHB word write / read strobe
- ahb_addr  in  ADDR_FIFO  AHB word address
- ahb_wdata  in  DATA_WIDTH  AHB write data
- ahb_rdata  out  DATA_WIDTH  AHB read data
- s_wr  in  1  stream write (RX)
- s_wdata  in  DATA_WIDTH  stream write data
- s_rd  in  1  stream read request (TX)
- s_rdata  out  DATA_WIDTH  stream read data
- s_rvalid  out  1  s_rdata valid pulse
- level  out  ADDR_FIFO+1  RX: words written; TX: words remaining
- full, empty, almost_full, almost_empty  out  1  status flags
- frame_done  out  1  one-cycle pulse at frame completion
- busy  out  1  state == RUN
- overflow, underflow  out  1  sticky error flags

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start with data_size in 1..DEPTH_FIFO → RUN.
  - Latch mode_q, size_q, base_q; count cleared.
  - Out-of-range data_size: start ignored, state unchanged.
- start is ignored while in RUN.
- flush from any state → IDLE.
  - Clears count, overflow and underflow.
  - No frame_done pulse; memory contents untouched.
  - Wins over start and over stream traffic in the same cycle.
- Stream address = base_q + count, wrapping DEPTH_FIFO-1 → 0 (compare-and-reset; no power-of-two modulo).
- RX RUN:
  - s_wr writes s_wdata at the stream address; count++.
  - When count reaches size_q → DONE, frame_done pulse.
  - s_wr in IDLE/DONE: dropped, overflow set.
  - s_rd ignored in RX.
- TX RUN:
  - s_rd while level > 0 reads the stream address; count++.
  - Final read → DONE, frame_done pulse.
  - s_rd when level == 0 (IDLE/DONE): underflow set, no s_rvalid.
  - s_wr ignored in TX.
- AHB writes:
  - Accepted in IDLE and DONE only; ignored in RUN for both modes.
  - Ignored for ahb_addr ≥ DEPTH_FIFO.
- AHB reads:
  - Accepted in every state.
  - ahb_addr ≥ DEPTH_FIFO returns 0.
- level by state:
  - IDLE: 0.
  - RX: count.
  - TX: size_q − count.
- empty = (level == 0).
- full = (state != IDLE) && (RX ? count == size_q : count == 0).
- Memory: DEPTH_FIFO × DATA_WIDTH, synchronous single write port.
  - Write owner: AHB in IDLE/DONE, stream in RX RUN.
  - Two synchronous read ports: stream and AHB.

## Timing
- Reset values:
  - state = IDLE; count, level = 0.
  - empty = 1, almost_empty = 1.
  - All other outputs 0, including s_rdata and ahb_rdata.
- start → busy = 1 and TX level = size_q on the next edge.
- s_rdata/s_rvalid: 1 cycle after the accepted s_rd; back-to-back s_rd gives one word per cycle.
- ahb_rdata: 1 cycle after ahb_re; holds until the next ahb_re.
- Same-address write and read in one cycle returns old data (read-before-write).
- frame_done is asserted in the same cycle state becomes DONE, i.e. the cycle after the final accepted s_wr/s_rd.
- Overflow/underflow are set on the edge after the offending strobe and hold until flush or reset.
- Asynchronous reset mid-frame: immediate return to reset values.

## Test plan
- TX basic:
  - AHB writes 0xA0..0xA3 to addresses 0..3; start with mode=1, data_size=4, base=0; s_rd held 4 cycles.
  - Required: s_rdata 0xA0..0xA3 on consecutive cycles; level 4→0; frame_done one cycle after the 4th s_rd; 5th s_rd sets underflow.
- RX wrap:
  - mode=0, base=198, data_size=4, DEPTH_FIFO=200; s_wr 0x11..0x14.
  - Required: words land at 198, 199, 0, 1; AHB reads them back with 1-cycle latency; full = 1 and frame_done pulse after the 4th write.
- Overflow:
  - After the RX frame completes, s_wr 0x55.
  - Required: overflow = 1, memory unchanged, level stays 4.
- Flush mid-frame:
  - RX size=10, 3 words written; flush and start in the same cycle.
  - Required: IDLE, level 0, empty = 1, busy 0, no frame_done, flags cleared.
- Guards:
  - start with data_size 0 or 201: state stays IDLE.
  - AHB write during RUN: memory unchanged.
  - AHB read of address 250: returns 0.
- Thresholds:
  - RX size=200; level sweeps 0→200.
  - Required: almost_empty drops at level 9; almost_full rises at level 192.
  - Async reset asserted at level 100: all outputs return to reset values immediately.
